layer_frame_sequencer: RTL and testbench

Frame-level controller that sits in front of one positron layer and its memory-to-stream drain. It cuts the incoming DMA posit stream into frames of NB_UPSTREAM_POSITRON words, generates the layer's start-of-frame and end-of-frame strobes, and blocks new input while a frame is still accumulating or draining. It also carries the DMA end-of-transfer marker through to the last result word of the same frame.

---
 rtl/layer_frame_sequencer.sv | 134 +++++++++++++
 tb/tb_layer_frame_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/layer_frame_sequencer.sv
// layer_frame_sequencer
//
// Frame-level controller in front of one positron layer and its
// memory-to-stream drain.  It cuts the DMA posit stream into frames of
// NB_UPSTREAM_POSITRON words, marks the first/last word of each frame
// towards the layer, holds off new input while a frame is accumulating or
// draining, and forwards the DMA end-of-transfer marker to the last result
// word of the same frame.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   s_rts_i/s_rtr_o   upstream valid/ready
//   s_eow_i           DMA last word (qualified by s_rts_i)
//   s_posit_i         upstream posit word
//   l_rts_o/l_rtr_i   valid/ready towards the layer
//   l_sow_o/l_eow_o   first/last word of frame (qualified by l_rts_o)
//   l_posit_o         posit word to the layer (straight wire)
//   l_done_i          layer accumulation finished, 1-cycle pulse
//   m_rts_i/m_rtr_i   drain handshake, monitored only
//   m_eow_o           tlast to downstream on the last drained word
//   busy_o            not idle
//   frame_cnt_o       completed frames, wraps at 2^16
//   err_short_o       sticky: DMA last word ended a frame early
//   err_early_o       sticky: l_done_i seen outside WAIT_ACC
module layer_frame_sequencer #(
    parameter int unsigned NB_UPSTREAM_POSITRON = 784,
    parameter int unsigned NB_POSITRON          = 20,
    parameter int unsigned POSIT_WIDTH          = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_rts_i,
    output logic                   s_rtr_o,
    input  logic                   s_eow_i,
    input  logic [POSIT_WIDTH-1:0] s_posit_i,
    output logic                   l_rts_o,
    input  logic                   l_rtr_i,
    output logic                   l_sow_o,
    output logic                   l_eow_o,
    output logic [POSIT_WIDTH-1:0] l_posit_o,
    input  logic                   l_done_i,
    input  logic                   m_rts_i,
    input  logic                   m_rtr_i,
    output logic                   m_eow_o,
    output logic                   busy_o,
    output logic [15:0]            frame_cnt_o,
    output logic                   err_short_o,
    output logic                   err_early_o
);

    localparam int unsigned WCW = $clog2(NB_UPSTREAM_POSITRON + 1);
    localparam int unsigned OCW = $clog2(NB_POSITRON + 1);
    localparam logic [WCW-1:0] WC_LAST = WCW'(NB_UPSTREAM_POSITRON - 1);
    localparam logic [OCW-1:0] OC_LAST = OCW'(NB_POSITRON - 1);

    typedef enum logic [1:0] {IDLE, FEED, WAIT_ACC, DRAIN} state_t;

    state_t         state;
    logic [WCW-1:0] wc;
    logic [OCW-1:0] oc;
    logic           tlast_pend;

    logic accepting;
    logic accept;
    logic drain_hs;
    logic oc_last;

    assign accepting = (state == IDLE) || (state == FEED);
    assign s_rtr_o   = accepting & l_rtr_i;
    assign l_rts_o   = accepting & s_rts_i;
    assign l_posit_o = s_posit_i;
    assign accept    = s_rts_i & s_rtr_o;
    assign drain_hs  = m_rts_i & m_rtr_i;
    assign oc_last   = (oc == OC_LAST);

    assign l_sow_o = s_rts_i & (state == IDLE);
    assign l_eow_o = s_rts_i & accepting & ((wc == WC_LAST) | s_eow_i);
    assign m_eow_o = tlast_pend & (state == DRAIN) & oc_last;
    assign busy_o  = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wc          <= '0;
            oc          <= '0;
            tlast_pend  <= 1'b0;
            frame_cnt_o <= '0;
            err_short_o <= 1'b0;
            err_early_o <= 1'b0;
        end else begin
            if (l_done_i && (state != WAIT_ACC))
                err_early_o <= 1'b1;

            unique case (state)
                // IDLE and FEED share one path: wc is 0 in IDLE, so wc+1
                // gives the required 1 for the first word of a frame.
                IDLE, FEED: begin
                    if (accept) begin
                        if (s_eow_i)
                            tlast_pend <= 1'b1;
                        if (s_eow_i && (wc < WC_LAST))
                            err_short_o <= 1'b1;
                        if (l_eow_o) begin
                            wc    <= '0;
                            state <= WAIT_ACC;
                        end else begin
                            wc    <= wc + WCW'(1);
                            state <= FEED;
                        end
                    end
                end
                WAIT_ACC: begin
                    if (l_done_i) begin
                        oc    <= '0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_hs) begin
                        if (oc_last) begin
                            state       <= IDLE;
                            frame_cnt_o <= frame_cnt_o + 16'd1;
                            tlast_pend  <= 1'b0;
                        end else begin
                            oc <= oc + OCW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_frame_sequencer.sv
// tb_layer_frame_sequencer
//
// Self-checking bench for layer_frame_sequencer (N=4 input words, 3 drain
// words per frame).  Directed frames from the test plan are followed by a
// long randomized run; a transaction-level model predicts every output.
module tb_layer_frame_sequencer;

    localparam int unsigned N   = 4;
    localparam int unsigned NBP = 3;
    localparam int unsigned PW  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_rts = 1'b0;
    logic          s_rtr;
    logic          s_eow = 1'b0;
    logic [PW-1:0] s_posit = '0;
    logic          l_rts;
    logic          l_rtr = 1'b0;
    logic          l_sow;
    logic          l_eow;
    logic [PW-1:0] l_posit;
    logic          l_done = 1'b0;
    logic          m_rts = 1'b0;
    logic          m_rtr = 1'b0;
    logic          m_eow;
    logic          busy;
    logic [15:0]   frame_cnt;
    logic          err_short;
    logic          err_early;

    layer_frame_sequencer #(
        .NB_UPSTREAM_POSITRON(N),
        .NB_POSITRON(NBP),
        .POSIT_WIDTH(PW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_rts_i(s_rts), .s_rtr_o(s_rtr), .s_eow_i(s_eow), .s_posit_i(s_posit),
        .l_rts_o(l_rts), .l_rtr_i(l_rtr), .l_sow_o(l_sow), .l_eow_o(l_eow),
        .l_posit_o(l_posit), .l_done_i(l_done),
        .m_rts_i(m_rts), .m_rtr_i(m_rtr), .m_eow_o(m_eow),
        .busy_o(busy), .frame_cnt_o(frame_cnt),
        .err_short_o(err_short), .err_early_o(err_early)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Transaction-level model: where we are in a frame, expressed as counts.
    bit          mdl_taking;     // input side open for words
    int unsigned mdl_words;      // words of the current frame taken so far
    bit          mdl_want_done;  // frame fed, waiting for the layer
    bit          mdl_draining;
    int unsigned mdl_drained;    // result words drained so far
    int unsigned mdl_frames;
    bit          mdl_tlast, mdl_eshort, mdl_eearly;

    // directed-stat counters
    int unsigned n_xfer, n_sow, n_eow;

    function automatic void mdl_reset();
        mdl_taking = 1; mdl_words = 0; mdl_want_done = 0;
        mdl_draining = 0; mdl_drained = 0; mdl_frames = 0;
        mdl_tlast = 0; mdl_eshort = 0; mdl_eearly = 0;
    endfunction

    // One clock cycle: drive, check combinational outputs, clock, update
    // the model, check registered outputs.  Called just after a posedge.
    task automatic step(input bit srts, input bit lrtr, input bit seow, input bit ldone,
                        input bit mrts, input bit mrtr, input logic [PW-1:0] posit);
        bit e_sow, e_eow, e_meow, took;
        s_rts = srts; l_rtr = lrtr; s_eow = seow; l_done = ldone;
        m_rts = mrts; m_rtr = mrtr; s_posit = posit;
        #2;
        e_sow  = srts && mdl_taking && (mdl_words == 0);
        e_eow  = srts && mdl_taking && ((mdl_words == N - 1) || seow);
        e_meow = mdl_draining && mdl_tlast && (mdl_drained == NBP - 1);
        took   = srts && lrtr && mdl_taking;
        check("s_rtr", 32'(s_rtr), 32'(mdl_taking && lrtr));
        check("l_rts", 32'(l_rts), 32'(mdl_taking && srts));
        check("l_sow", 32'(l_sow), 32'(e_sow));
        check("l_eow", 32'(l_eow), 32'(e_eow));
        check("m_eow", 32'(m_eow), 32'(e_meow));
        check("l_posit", 32'(l_posit), 32'(posit));
        if (took) begin
            n_xfer++;
            if (e_sow) n_sow++;
            if (e_eow) n_eow++;
        end
        @(posedge clk);
        #1;
        if (ldone && !mdl_want_done) mdl_eearly = 1;
        if (took) begin
            if (seow) mdl_tlast = 1;
            if (seow && mdl_words < N - 1) mdl_eshort = 1;
            if (e_eow) begin
                mdl_words = 0; mdl_taking = 0; mdl_want_done = 1;
            end else begin
                mdl_words++;
            end
        end else if (mdl_want_done && ldone) begin
            mdl_want_done = 0; mdl_draining = 1; mdl_drained = 0;
        end else if (mdl_draining && mrts && mrtr) begin
            if (mdl_drained == NBP - 1) begin
                mdl_draining = 0; mdl_taking = 1;
                mdl_frames = (mdl_frames + 1) % 65536; mdl_tlast = 0;
            end else begin
                mdl_drained++;
            end
        end
        check("busy", 32'(busy), 32'(!(mdl_taking && mdl_words == 0)));
        check("frame_cnt", 32'(frame_cnt), 32'(mdl_frames));
        check("err_short", 32'(err_short), 32'(mdl_eshort));
        check("err_early", 32'(err_early), 32'(mdl_eearly));
    endtask

    task automatic do_reset();
        s_rts = 0; l_rtr = 0; s_eow = 0; l_done = 0; m_rts = 0; m_rtr = 0;
        rst_n = 0;
        #2;
        mdl_reset();
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_frame_cnt", 32'(frame_cnt), 32'(0));
        check("rst_err_short", 32'(err_short), 32'(0));
        check("rst_err_early", 32'(err_early), 32'(0));
        check("rst_l_sow", 32'(l_sow), 32'(0));
        check("rst_m_eow", 32'(m_eow), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    // Feed N words (eow_at < N marks s_eow on that word), then done and drain.
    task automatic frame(input int unsigned eow_at);
        for (int unsigned i = 0; i < N; i++) begin
            step(1, 1, i == eow_at, 0, 0, 0, 16'(i + 16'h100));
            if (i == eow_at) break;
        end
        step(1, 1, 0, 0, 0, 0, 16'h0bad);   // must be blocked
        step(0, 0, 0, 1, 0, 0, 16'h0);
        for (int unsigned k = 0; k < NBP; k++)
            step(0, 0, 0, 0, 1, 1, 16'h0);
    endtask

    initial begin
        mdl_reset();
        #3;
        do_reset();

        // plain frame, then DMA-last on final word, then plain again
        frame(N);
        frame(N - 1);
        frame(N);
        check("frames_directed", 32'(frame_cnt), 32'(3));

        // short frame: DMA last on word 1
        frame(1);
        check("short_flag", 32'(err_short), 32'(1));

        // toggling layer ready: exactly N transfers, one sow, one eow
        n_xfer = 0; n_sow = 0; n_eow = 0;
        for (int unsigned i = 0; i < 2 * N; i++)
            step(1, (i % 2) == 0, 0, 0, 0, 0, 16'(i));
        check("toggle_xfers", 32'(n_xfer), 32'(N));
        check("toggle_sow", 32'(n_sow), 32'(1));
        check("toggle_eow", 32'(n_eow), 32'(1));
        step(0, 0, 0, 1, 0, 0, 16'h0);
        for (int unsigned k = 0; k < NBP; k++)
            step(0, 0, 0, 0, 1, 1, 16'h0);

        // early done during FEED, frame then completes
        step(1, 1, 0, 0, 0, 0, 16'h11);
        step(0, 0, 0, 1, 0, 0, 16'h0);
        check("early_flag", 32'(err_early), 32'(1));
        for (int unsigned i = 1; i < N; i++)
            step(1, 1, 0, 0, 0, 0, 16'(i));
        step(0, 0, 0, 1, 0, 0, 16'h0);
        for (int unsigned k = 0; k < NBP; k++)
            step(0, 0, 0, 0, 1, 1, 16'h0);

        // reset mid-frame after two words; next word is a fresh sow
        do_reset();
        step(1, 1, 0, 0, 0, 0, 16'h21);
        step(1, 1, 0, 0, 0, 0, 16'h22);
        do_reset();
        n_sow = 0;
        step(1, 1, 0, 0, 0, 0, 16'h23);
        check("sow_after_reset", 32'(n_sow), 32'(1));

        // randomized traffic
        for (int unsigned c = 0; c < 4000; c++) begin
            bit ld;
            if (mdl_want_done) ld = ($urandom_range(0, 99) < 40);
            else               ld = ($urandom_range(0, 99) < 2);
            step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 70,
                 $urandom_range(0, 99) < 8, ld,
                 $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 60,
                 16'($urandom));
            if (c == 2500) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
